// File: rtl/ceres_pkg.sv
// ============================================================================
// Package  : ceres_pkg
// Purpose  : Shared widths and types for the lowX memory arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ceres_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BLK_SIZE = 128;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [XLEN-1:0]     addr;
    logic [1:0]          rw_size;
    logic                rw;
    logic [BLK_SIZE-1:0] data;
    logic                uncached;
  } lowX_req_t;

  typedef struct packed {
    logic                valid;
    logic                ready;
    logic [BLK_SIZE-1:0] data;
  } lowX_res_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_IC = 1'b0,
    ARB_DC = 1'b1
  } arb_port_e;

endpackage

`default_nettype wire

// File: rtl/lowx_arb_pick.sv
// ============================================================================
// Module   : lowx_arb_pick
// Purpose  : Combinational two-way picker; tie rule selected by
//            LOWX_ARB_ROUND_ROBIN_EN (round-robin) or fixed dcache priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lowx_arb_pick
  import ceres_pkg::*;
(
  input  logic      ic_v,
  input  logic      dc_v,
  input  arb_port_e last,
  output arb_port_e winner,
  output logic      any
);

`ifndef LOWX_ARB_ROUND_ROBIN_EN
  // Fixed priority keeps the history input only for interface compatibility.
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    any    = ic_v | dc_v;
    winner = ARB_IC;
    if (ic_v && dc_v) begin
`ifdef LOWX_ARB_ROUND_ROBIN_EN
      winner = (last == ARB_IC) ? ARB_DC : ARB_IC;
`else
      winner = ARB_DC;
`endif
    end else if (dc_v) begin
      winner = ARB_DC;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lowx_mem_arbiter.sv
// ============================================================================
// Module   : lowx_mem_arbiter
// Purpose  : Arbitrates icache/dcache lowX requests onto one memory port and
//            routes the response back. Tie rule: LOWX_ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lowx_mem_arbiter #(
  parameter int unsigned XLEN     = ceres_pkg::XLEN,
  parameter int unsigned BLK_SIZE = ceres_pkg::BLK_SIZE
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [XLEN+BLK_SIZE+5:0] icache_req_i,
  output logic [BLK_SIZE+1:0]      icache_res_o,
  input  logic [XLEN+BLK_SIZE+5:0] dcache_req_i,
  output logic [BLK_SIZE+1:0]      dcache_res_o,
  output logic [XLEN+BLK_SIZE+5:0] mem_req_o,
  input  logic [BLK_SIZE+1:0]      mem_res_i,
  output logic                     busy_o
);

  import ceres_pkg::*;

  lowX_req_t  ic_req;
  lowX_req_t  dc_req;
  lowX_req_t  req_q;
  lowX_req_t  mem_req;
  lowX_res_t  mem_res;
  lowX_res_t  fwd;
  lowX_res_t  ic_res;
  lowX_res_t  dc_res;
  arb_state_e state_q;
  arb_state_e state_d;
  arb_port_e  grant_q;
  arb_port_e  last_q;
  arb_port_e  winner;
  logic       any_valid;
  logic       take_grant;
  logic       complete;

  assign ic_req  = icache_req_i;
  assign dc_req  = dcache_req_i;
  assign mem_res = mem_res_i;

  lowx_arb_pick u_pick (
    .ic_v   (ic_req.valid),
    .dc_v   (dc_req.valid),
    .last   (last_q),
    .winner (winner),
    .any    (any_valid)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= '0;
      grant_q <= ARB_IC;
      last_q  <= ARB_IC;
    end else begin
      state_q <= state_d;
      if (take_grant) begin
        grant_q <= winner;
        req_q   <= (winner == ARB_DC) ? dc_req : ic_req;
      end
      if (complete) begin
        last_q <= grant_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    take_grant = 1'b0;
    complete   = 1'b0;
    mem_req    = '0;
    fwd        = '0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          take_grant = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        mem_req       = req_q;
        mem_req.valid = 1'b1;
        fwd.ready     = mem_res.ready;
        if (mem_res.ready) begin
          if (mem_res.valid) begin
            fwd.valid = 1'b1;
            fwd.data  = mem_res.data;
            complete  = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = RESP;
          end
        end
      end
      RESP: begin
        // Memory has accepted; only the data/ack beat matters from here.
        mem_req       = req_q;
        mem_req.valid = 1'b0;
        if (mem_res.valid) begin
          fwd.valid = 1'b1;
          fwd.data  = mem_res.data;
          complete  = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ic_res = '0;
    dc_res = '0;
    if (grant_q == ARB_DC) begin
      dc_res = fwd;
    end else begin
      ic_res = fwd;
    end
  end

  assign mem_req_o    = mem_req;
  assign icache_res_o = ic_res;
  assign dcache_res_o = dc_res;
  assign busy_o       = (state_q != IDLE);

endmodule

`default_nettype wire
